// File: rtl/ctrl_multiciclo.sv
// Multicycle main control FSM for the MIPS subset: sequences fetch/decode/execute/memory/writeback
// and drives ALUOp plus datapath enables. Debug state codes: FETCH=0 .. JUMP=11 (see state_t).
module ctrl_multiciclo #(
   parameter logic [3:0] ALUOP_ADD = 4'b1111
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [3:0] ALUOp,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       ext_zero,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WRITE = 4'd4,
      S_MEM_WB    = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_I_EXEC    = 4'd8,
      S_I_WB      = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11
   } state_t;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t     state_q, state_d;
   logic [5:0] op_q, op_d;

   logic [3:0] aluop_c;
   logic       src_a_c, ext_zero_c, pc_en_c, iord_c, mem_read_c, mem_write_c;
   logic       ir_write_c, reg_dst_c, mem_to_reg_c, reg_write_c, illegal_c;
   logic [1:0] src_b_c, pc_src_c;
   logic       logic_imm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   assign logic_imm = (op_q == OP_ANDI) || (op_q == OP_ORI) || (op_q == OP_XORI);

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      aluop_c      = '0;
      src_a_c      = 1'b0;
      src_b_c      = 2'b00;
      ext_zero_c   = 1'b0;
      pc_src_c     = 2'b00;
      pc_en_c      = 1'b0;
      iord_c       = 1'b0;
      mem_read_c   = 1'b0;
      mem_write_c  = 1'b0;
      ir_write_c   = 1'b0;
      reg_dst_c    = 1'b0;
      mem_to_reg_c = 1'b0;
      reg_write_c  = 1'b0;
      illegal_c    = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mem_read_c = 1'b1;
            src_b_c    = 2'b01;
            aluop_c    = ALUOP_ADD;
            ir_write_c = mem_ready;
            pc_en_c    = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            // ALUOut gets the branch target speculatively; opcode is sampled live here.
            src_b_c = 2'b11;
            aluop_c = ALUOP_ADD;
            op_d    = opcode;
            case (opcode)
               OP_LW, OP_SW:                 state_d = S_MEM_ADDR;
               OP_R:                         state_d = S_R_EXEC;
               OP_ADDI, OP_SLTI, OP_SLTIU,
               OP_ANDI, OP_ORI, OP_XORI:     state_d = S_I_EXEC;
               OP_BEQ, OP_BNE:               state_d = S_BRANCH;
               OP_J:                         state_d = S_JUMP;
               default: begin
                  state_d   = S_FETCH;
                  illegal_c = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: begin
            src_a_c = 1'b1;
            src_b_c = 2'b10;
            aluop_c = ALUOP_ADD;
            state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            mem_read_c = 1'b1;
            iord_c     = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WRITE: begin
            mem_write_c = 1'b1;
            iord_c      = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_MEM_WB: begin
            reg_write_c  = 1'b1;
            mem_to_reg_c = 1'b1;
            state_d      = S_FETCH;
         end
         S_R_EXEC: begin
            src_a_c = 1'b1;
            state_d = S_R_WB;
         end
         S_R_WB: begin
            reg_write_c = 1'b1;
            reg_dst_c   = 1'b1;
            state_d     = S_FETCH;
         end
         S_I_EXEC: begin
            src_a_c    = 1'b1;
            src_b_c    = 2'b10;
            aluop_c    = op_q[3:0];
            ext_zero_c = logic_imm;
            state_d    = S_I_WB;
         end
         S_I_WB: begin
            // ALU controls held so the result stays stable through the write.
            aluop_c     = op_q[3:0];
            ext_zero_c  = logic_imm;
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            src_a_c  = 1'b1;
            aluop_c  = op_q[3:0];
            pc_src_c = 2'b01;
            pc_en_c  = (op_q == OP_BNE) ? ~zero : zero;
            state_d  = S_FETCH;
         end
         S_JUMP: begin
            pc_src_c = 2'b10;
            pc_en_c  = 1'b1;
            state_d  = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Outputs are forced low while reset is held so nothing in the datapath moves.
   assign ALUOp      = rst_n ? aluop_c : 4'b0000;
   assign alu_src_a  = rst_n & src_a_c;
   assign alu_src_b  = rst_n ? src_b_c : 2'b00;
   assign ext_zero   = rst_n & ext_zero_c;
   assign pc_src     = rst_n ? pc_src_c : 2'b00;
   assign pc_en      = rst_n & pc_en_c;
   assign iord       = rst_n & iord_c;
   assign mem_read   = rst_n & mem_read_c;
   assign mem_write  = rst_n & mem_write_c;
   assign ir_write   = rst_n & ir_write_c;
   assign reg_dst    = rst_n & reg_dst_c;
   assign mem_to_reg = rst_n & mem_to_reg_c;
   assign reg_write  = rst_n & reg_write_c;
   assign illegal_op = rst_n & illegal_c;
   assign state      = state_q;

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Bench for ctrl_multiciclo: opcode table, hand-written wait/reset sequences and a randomized
// run, all checked cycle by cycle against a phase-list model of the instruction flow.
module tb_ctrl_multiciclo;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic [3:0] ALUOp, state;
   logic       alu_src_a, ext_zero, pc_en, iord, mem_read, mem_write;
   logic       ir_write, reg_dst, mem_to_reg, reg_write, illegal_op;
   logic [1:0] alu_src_b, pc_src;

   ctrl_multiciclo dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
      .pc_src(pc_src), .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] aluop;
      logic       src_a;
      logic [1:0] src_b;
      logic       ez;
      logic [1:0] pc_src;
      logic       pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, ill;
      logic [3:0] st;
   } outs_t;

   outs_t got;
   assign got = {ALUOp, alu_src_a, alu_src_b, ext_zero, pc_src, pc_en, iord, mem_read,
                 mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal_op, state};

   // Debug state codes exposed on the state port
   localparam int P_FETCH = 0, P_DECODE = 1, P_MADDR = 2, P_MRD = 3, P_MWR = 4, P_MWB = 5;
   localparam int P_REX = 6, P_RWB = 7, P_IEX = 8, P_IWB = 9, P_BR = 10, P_J = 11;

   logic [5:0] legal_ops [12] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
      6'b001000, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b000010};

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   typedef int iq_t[$];

   // Phases an instruction walks through, from the instruction-class rules.
   function automatic iq_t plan(input logic [5:0] op);
      iq_t q;
      q = '{P_FETCH, P_DECODE};
      if (!is_legal(op))                         ;
      else if (op == 6'b100011)                  q = {q, P_MADDR, P_MRD, P_MWB};
      else if (op == 6'b101011)                  q = {q, P_MADDR, P_MWR};
      else if (op == 6'b000000)                  q = {q, P_REX, P_RWB};
      else if (op == 6'b000100 || op == 6'b000101) q.push_back(P_BR);
      else if (op == 6'b000010)                  q.push_back(P_J);
      else                                       q = {q, P_IEX, P_IWB};
      return q;
   endfunction

   function automatic outs_t model(input int ph, input logic [5:0] op, input logic mr, input logic z);
      outs_t o;
      bit logic_imm;
      o = '0;
      o.st = 4'(ph);
      logic_imm = (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001110);
      case (ph)
         P_FETCH:  begin o.mrd = 1; o.src_b = 2'b01; o.aluop = 4'hF; o.irw = mr; o.pc_en = mr; end
         P_DECODE: begin o.src_b = 2'b11; o.aluop = 4'hF; o.ill = !is_legal(op); end
         P_MADDR:  begin o.src_a = 1; o.src_b = 2'b10; o.aluop = 4'hF; end
         P_MRD:    begin o.mrd = 1; o.iord = 1; end
         P_MWR:    begin o.mwr = 1; o.iord = 1; end
         P_MWB:    begin o.rw = 1; o.m2r = 1; end
         P_REX:    begin o.src_a = 1; end
         P_RWB:    begin o.rw = 1; o.rdst = 1; end
         P_IEX:    begin o.src_a = 1; o.src_b = 2'b10; o.aluop = op[3:0]; o.ez = logic_imm; end
         P_IWB:    begin o.rw = 1; o.aluop = op[3:0]; o.ez = logic_imm; end
         P_BR:     begin o.src_a = 1; o.aluop = op[3:0]; o.pc_src = 2'b01;
                         o.pc_en = (op == 6'b000101) ? !z : z; end
         P_J:      begin o.pc_src = 2'b10; o.pc_en = 1; end
         default: ;
      endcase
      return o;
   endfunction

   // One cycle: drive, check against model, advance past the edge.
   task automatic cyc(input int ph, input logic [5:0] op, input logic mr, input logic z,
                      output outs_t s);
      opcode    = (ph == P_DECODE) ? op : 6'($urandom);
      mem_ready = mr;
      zero      = z;
      #1;
      s = got;
      chk($sformatf("cycle ph%0d op%b", ph, op), 32'(got), 32'(model(ph, op, mr, z)));
      @(posedge clk); #1;
   endtask

   task automatic run_instr(input logic [5:0] op, input bit rnd, input int fw, input int rw,
                            input logic zz, output int cycles, output logic [3:0] alu3,
                            output logic ez3, output int n_irw, output int n_pc, output int n_ill);
      iq_t q;
      int ph, waits;
      bit is_mem;
      logic mr, z;
      outs_t s;
      q = plan(op);
      cycles = 0; alu3 = '0; ez3 = 1'b0; n_irw = 0; n_pc = 0; n_ill = 0;
      while (q.size() > 0) begin
         ph = q.pop_front();
         is_mem = (ph == P_FETCH) || (ph == P_MRD) || (ph == P_MWR);
         waits = (ph == P_FETCH) ? fw : (ph == P_MRD) ? rw : (ph == P_MWR) ? rw : 0;
         do begin
            mr = rnd ? 1'($urandom) : (waits > 0 ? 1'b0 : 1'b1);
            z  = rnd ? 1'($urandom) : zz;
            cyc(ph, op, mr, z, s);
            cycles++;
            if (cycles == 3) begin alu3 = s.aluop; ez3 = s.ez; end
            n_irw += int'(s.irw);
            n_pc  += int'(s.pc_en);
            n_ill += int'(s.ill);
            waits--;
         end while (is_mem && !mr && cycles < 500);
      end
   endtask

   typedef struct {
      logic [5:0] op;
      int         cyc;
      logic [3:0] alu3;
      logic       ez3;
      int         npc;
      int         nill;
   } vec_t;

   initial begin
      vec_t tbl[13];
      int cycles, n_irw, n_pc, n_ill;
      logic [3:0] alu3;
      logic ez3;
      logic [5:0] op;
      outs_t s;

      tbl[0]  = '{6'b000000, 4, 4'b0000, 1'b0, 1, 0};
      tbl[1]  = '{6'b100011, 5, 4'b1111, 1'b0, 1, 0};
      tbl[2]  = '{6'b101011, 4, 4'b1111, 1'b0, 1, 0};
      tbl[3]  = '{6'b000100, 3, 4'b0100, 1'b0, 2, 0};
      tbl[4]  = '{6'b000101, 3, 4'b0101, 1'b0, 1, 0};
      tbl[5]  = '{6'b001000, 4, 4'b1000, 1'b0, 1, 0};
      tbl[6]  = '{6'b001010, 4, 4'b1010, 1'b0, 1, 0};
      tbl[7]  = '{6'b001011, 4, 4'b1011, 1'b0, 1, 0};
      tbl[8]  = '{6'b001100, 4, 4'b1100, 1'b1, 1, 0};
      tbl[9]  = '{6'b001101, 4, 4'b1101, 1'b1, 1, 0};
      tbl[10] = '{6'b001110, 4, 4'b1110, 1'b1, 1, 0};
      tbl[11] = '{6'b000010, 3, 4'b0000, 1'b0, 2, 0};
      tbl[12] = '{6'b111111, 2, 4'b0000, 1'b0, 1, 1};

      // Reset: everything low even with mem_ready high
      mem_ready = 1'b1;
      #2;
      chk("reset outs", 32'(got), 32'd0);
      @(posedge clk); #1;
      chk("reset outs held", 32'(got), 32'd0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         run_instr(tbl[i].op, 1'b0, 0, 0, 1'b1, cycles, alu3, ez3, n_irw, n_pc, n_ill);
         chk($sformatf("latency op%b", tbl[i].op), 32'(cycles), 32'(tbl[i].cyc));
         if (tbl[i].cyc >= 3) begin
            chk($sformatf("aluop op%b", tbl[i].op), 32'(alu3), 32'(tbl[i].alu3));
            chk($sformatf("ext_zero op%b", tbl[i].op), 32'(ez3), 32'(tbl[i].ez3));
         end
         chk($sformatf("pc_en count op%b", tbl[i].op), 32'(n_pc), 32'(tbl[i].npc));
         chk($sformatf("illegal count op%b", tbl[i].op), 32'(n_ill), 32'(tbl[i].nill));
      end

      // lw with 2 fetch waits and 3 read waits
      run_instr(6'b100011, 1'b0, 2, 3, 1'b0, cycles, alu3, ez3, n_irw, n_pc, n_ill);
      chk("lw waits latency", 32'(cycles), 32'd10);
      chk("lw waits ir_write count", 32'(n_irw), 32'd1);
      chk("lw waits pc_en count", 32'(n_pc), 32'd1);

      // Reset during a stalled store
      cyc(P_FETCH, 6'b101011, 1'b1, 1'b0, s);
      cyc(P_DECODE, 6'b101011, 1'b1, 1'b0, s);
      cyc(P_MADDR, 6'b101011, 1'b1, 1'b0, s);
      mem_ready = 1'b0;
      #1;
      chk("mem_write stalled", 32'(mem_write), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mem_write async drop", 32'(mem_write), 32'd0);
      chk("outs in reset", 32'(got), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("state after release", 32'(state), 32'(P_FETCH));
      chk("mem_read after release", 32'(mem_read), 32'd1);
      @(posedge clk); #1;
      mem_ready = 1'b1;

      // Randomized mix, including unsupported opcodes and random handshakes
      repeat (150) begin
         op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 11)];
         run_instr(op, 1'b1, 0, 0, 1'b0, cycles, alu3, ez3, n_irw, n_pc, n_ill);
         chk($sformatf("rnd ir_write count op%b", op), 32'(n_irw), 32'd1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
